// File: rtl/elevator_scheduler.sv
// LOOK-policy request scheduler driving the elevator's target/stop inputs.
// Define ELEVATOR_SCHED_HOLD_EN to add the door_hold input that extends the door interval.
module elevator_scheduler #(
   parameter int DOOR_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] call_req,
`ifdef ELEVATOR_SCHED_HOLD_EN
   input  logic       door_hold,
`endif
   input  logic [1:0] floor,
   output logic [1:0] target,
   output logic       stop,
   output logic       door_open,
   output logic       dir_up,
   output logic [3:0] pending,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

   localparam logic [3:0] DOOR_LOAD = 4'(DOOR_CYCLES - 1);

   state_t     state_reg, state_next;
   logic [1:0] target_reg, target_next;
   logic       stop_reg, stop_next;
   logic       door_reg, door_next;
   logic       dir_reg, dir_next;
   logic [3:0] pending_reg, pending_next;
   logic       busy_reg, busy_next;
   logic [3:0] timer_reg, timer_next;

   logic       hold_req;
   logic [3:0] floor_onehot;
   logic [3:0] above, below;
   logic       up_found, down_found;
   logic [1:0] up_sel, down_sel;
   logic [3:0] set_mask, clr_mask;

`ifdef ELEVATOR_SCHED_HOLD_EN
   assign hold_req = door_hold;
`else
   assign hold_req = 1'b0;
`endif

   assign floor_onehot = 4'b0001 << floor;

   // Pending calls strictly above / below the reported floor.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_side
         assign above[gi] = pending_reg[gi] && (2'(gi) > floor);
         assign below[gi] = pending_reg[gi] && (2'(gi) < floor);
      end
   endgenerate

   assign up_found   = |above;
   assign down_found = |below;
   assign up_sel     = above[1] ? 2'd1 : (above[2] ? 2'd2 : 2'd3);
   assign down_sel   = below[2] ? 2'd2 : (below[1] ? 2'd1 : 2'd0);

   always_comb begin
      state_next  = state_reg;
      target_next = target_reg;
      stop_next   = stop_reg;
      door_next   = door_reg;
      dir_next    = dir_reg;
      timer_next  = timer_reg;
      clr_mask    = 4'b0000;
      // A same-floor call during DOOR extends the door instead of latching.
      set_mask    = (state_reg == DOOR) ? (call_req & ~floor_onehot) : call_req;

      case (state_reg)
         IDLE: begin
            target_next = floor;
            stop_next   = 1'b1;
            if (pending_reg[floor]) begin
               state_next = DOOR;
               door_next  = 1'b1;
               clr_mask   = floor_onehot;
               timer_next = DOOR_LOAD;
            end else if (dir_reg ? up_found : down_found) begin
               target_next = dir_reg ? up_sel : down_sel;
               stop_next   = 1'b0;
               state_next  = MOVE;
            end else if (dir_reg ? down_found : up_found) begin
               dir_next    = ~dir_reg;
               target_next = dir_reg ? down_sel : up_sel;
               stop_next   = 1'b0;
               state_next  = MOVE;
            end
         end
         MOVE: begin
            if (floor == target_reg) begin
               state_next = DOOR;
               stop_next  = 1'b1;
               door_next  = 1'b1;
               clr_mask   = floor_onehot;
               timer_next = DOOR_LOAD;
            end else if (dir_reg ? up_found : down_found) begin
               target_next = dir_reg ? up_sel : down_sel;
            end
         end
         DOOR: begin
            if (call_req[floor] || hold_req) begin
               timer_next = DOOR_LOAD;
            end else if (timer_reg == 4'd0) begin
               door_next   = 1'b0;
               target_next = floor;
               state_next  = IDLE;
            end else begin
               timer_next = timer_reg - 4'd1;
            end
         end
         default: begin
            state_next = IDLE;
            stop_next  = 1'b1;
            door_next  = 1'b0;
         end
      endcase

      // Clear wins over a simultaneous set on the same bit.
      pending_next = (pending_reg | set_mask) & ~clr_mask;
      busy_next    = (state_next != IDLE) || (pending_next != 4'b0000);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= IDLE;
         target_reg  <= 2'd0;
         stop_reg    <= 1'b1;
         door_reg    <= 1'b0;
         dir_reg     <= 1'b1;
         pending_reg <= 4'b0000;
         busy_reg    <= 1'b0;
         timer_reg   <= 4'd0;
      end else begin
         state_reg   <= state_next;
         target_reg  <= target_next;
         stop_reg    <= stop_next;
         door_reg    <= door_next;
         dir_reg     <= dir_next;
         pending_reg <= pending_next;
         busy_reg    <= busy_next;
         timer_reg   <= timer_next;
      end
   end

   assign target    = target_reg;
   assign stop      = stop_reg;
   assign door_open = door_reg;
   assign dir_up    = dir_reg;
   assign pending   = pending_reg;
   assign busy      = busy_reg;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed self-checking bench for elevator_scheduler; inputs driven and outputs sampled on the falling edge.
module tb_elevator_scheduler;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] call_req = 4'b0000;
   logic [1:0] floor = 2'd0;
   logic       door_hold = 1'b0;
   logic [1:0] target;
   logic       stop;
   logic       door_open;
   logic       dir_up;
   logic [3:0] pending;
   logic       busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   elevator_scheduler #(.DOOR_CYCLES(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .call_req  (call_req),
`ifdef ELEVATOR_SCHED_HOLD_EN
      .door_hold (door_hold),
`endif
      .floor     (floor),
      .target    (target),
      .stop      (stop),
      .door_open (door_open),
      .dir_up    (dir_up),
      .pending   (pending),
      .busy      (busy)
   );

   // Counts door_open-high samples, starting from the current (already high) one.
   task automatic count_door(output int n);
      n = 1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!door_open) break;
         n++;
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({target, stop, door_open, dir_up, pending, busy} !== {2'd0, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0}) begin
         errors++;
         $display("FAIL reset_values: got t=%0d s=%b d=%b up=%b p=%b b=%b, want t=0 s=1 d=0 up=1 p=0000 b=0",
                  target, stop, door_open, dir_up, pending, busy);
      end
      rst = 1'b0;
      @(negedge clk);
      $display("reset: t=%0d s=%b p=%b", target, stop, pending);
   endtask

   task automatic test_single_call();
      int n;
      floor = 2'd0;
      call_req = 4'b1000;
      @(negedge clk);
      call_req = 4'b0000;
      checks++;
      if (pending !== 4'b1000 || stop !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL single_latch: got p=%b s=%b b=%b, want p=1000 s=1 b=1", pending, stop, busy);
      end
      @(negedge clk);
      checks++;
      if (target !== 2'd3 || stop !== 1'b0 || dir_up !== 1'b1) begin
         errors++;
         $display("FAIL single_move: got t=%0d s=%b up=%b, want t=3 s=0 up=1", target, stop, dir_up);
      end
      floor = 2'd1; @(negedge clk);
      floor = 2'd2; @(negedge clk);
      floor = 2'd3; @(negedge clk);
      checks++;
      if (stop !== 1'b1 || door_open !== 1'b1 || pending !== 4'b0000) begin
         errors++;
         $display("FAIL single_arrive: got s=%b d=%b p=%b, want s=1 d=1 p=0000", stop, door_open, pending);
      end
      count_door(n);
      checks++;
      if (n !== 4) begin
         errors++;
         $display("FAIL single_door_len: got %0d cycles, want 4", n);
      end
      checks++;
      if (busy !== 1'b0 || stop !== 1'b1 || target !== 2'd3) begin
         errors++;
         $display("FAIL single_idle: got b=%b s=%b t=%0d, want b=0 s=1 t=3", busy, stop, target);
      end
      $display("single_call: door cycles=%0d", n);
   endtask

   task automatic test_intercept();
      int n;
      floor = 2'd0;
      @(negedge clk);
      call_req = 4'b1000;
      @(negedge clk);
      call_req = 4'b0000;
      @(negedge clk);
      call_req = 4'b0100;
      @(negedge clk);
      call_req = 4'b0000;
      checks++;
      if (pending !== 4'b1100 || target !== 2'd3) begin
         errors++;
         $display("FAIL intercept_latch: got p=%b t=%0d, want p=1100 t=3", pending, target);
      end
      @(negedge clk);
      checks++;
      if (target !== 2'd2 || stop !== 1'b0) begin
         errors++;
         $display("FAIL intercept_target: got t=%0d s=%b, want t=2 s=0", target, stop);
      end
      floor = 2'd1; @(negedge clk);
      floor = 2'd2; @(negedge clk);
      checks++;
      if (door_open !== 1'b1 || stop !== 1'b1 || pending !== 4'b1000) begin
         errors++;
         $display("FAIL intercept_door2: got d=%b s=%b p=%b, want d=1 s=1 p=1000", door_open, stop, pending);
      end
      count_door(n);
      checks++;
      if (stop !== 1'b1) begin
         errors++;
         $display("FAIL intercept_idle_gap: got s=%b after door, want s=1", stop);
      end
      @(negedge clk);
      checks++;
      if (target !== 2'd3 || stop !== 1'b0) begin
         errors++;
         $display("FAIL intercept_resume: got t=%0d s=%b, want t=3 s=0", target, stop);
      end
      floor = 2'd3; @(negedge clk);
      checks++;
      if (door_open !== 1'b1 || pending !== 4'b0000) begin
         errors++;
         $display("FAIL intercept_door3: got d=%b p=%b, want d=1 p=0000", door_open, pending);
      end
      count_door(n);
      $display("intercept: door at 3 cycles=%0d", n);
   endtask

   task automatic test_reversal();
      int n;
      floor = 2'd2;
      @(negedge clk);
      call_req = 4'b0001;
      @(negedge clk);
      call_req = 4'b0000;
      @(negedge clk);
      checks++;
      if (dir_up !== 1'b0 || target !== 2'd0 || stop !== 1'b0) begin
         errors++;
         $display("FAIL reversal: got up=%b t=%0d s=%b, want up=0 t=0 s=0", dir_up, target, stop);
      end
      floor = 2'd1; @(negedge clk);
      floor = 2'd0; @(negedge clk);
      checks++;
      if (door_open !== 1'b1) begin
         errors++;
         $display("FAIL reversal_door: got d=%b, want d=1", door_open);
      end
      count_door(n);
      $display("reversal: dir=%b door cycles=%0d", dir_up, n);
   endtask

   task automatic test_same_floor_door();
      int n;
      floor = 2'd1;
      @(negedge clk);
      call_req = 4'b0010;
      @(negedge clk);
      call_req = 4'b0000;
      @(negedge clk);
      checks++;
      if (door_open !== 1'b1 || pending !== 4'b0000) begin
         errors++;
         $display("FAIL same_floor_open: got d=%b p=%b, want d=1 p=0000", door_open, pending);
      end
      @(negedge clk);
      call_req = 4'b0010;
      @(negedge clk);
      call_req = 4'b0000;
      checks++;
      if (pending[1] !== 1'b0 || door_open !== 1'b1) begin
         errors++;
         $display("FAIL same_floor_nolatch: got p=%b d=%b, want p[1]=0 d=1", pending, door_open);
      end
      count_door(n);
      checks++;
      if (n !== 4) begin
         errors++;
         $display("FAIL same_floor_reload: got %0d remaining cycles, want 4 (6 total)", n);
      end
      $display("same_floor_door: total door cycles=%0d", n + 2);
   endtask

   task automatic test_async_reset();
      floor = 2'd0;
      @(negedge clk);
      call_req = 4'b1010;
      @(negedge clk);
      call_req = 4'b0000;
      @(negedge clk);
      checks++;
      if (stop !== 1'b0 || pending !== 4'b1010) begin
         errors++;
         $display("FAIL areset_setup: got s=%b p=%b, want s=0 p=1010", stop, pending);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({target, stop, door_open, dir_up, pending, busy} !== {2'd0, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0}) begin
         errors++;
         $display("FAIL areset_immediate: got t=%0d s=%b d=%b up=%b p=%b b=%b, want t=0 s=1 d=0 up=1 p=0000 b=0",
                  target, stop, door_open, dir_up, pending, busy);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (stop !== 1'b1 || pending !== 4'b0000 || busy !== 1'b0) begin
         errors++;
         $display("FAIL areset_no_motion: got s=%b p=%b b=%b, want s=1 p=0000 b=0", stop, pending, busy);
      end
      $display("async_reset: s=%b p=%b", stop, pending);
   endtask

`ifdef ELEVATOR_SCHED_HOLD_EN
   task automatic test_hold();
      int n;
      floor = 2'd0;
      call_req = 4'b0001;
      @(negedge clk);
      call_req = 4'b0000;
      @(negedge clk);
      door_hold = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (door_open !== 1'b1) begin
            errors++;
            $display("FAIL hold_open: cycle %0d got d=%b, want 1", i, door_open);
         end
      end
      door_hold = 1'b0;
      count_door(n);
      checks++;
      if (n !== 4) begin
         errors++;
         $display("FAIL hold_tail: got %0d cycles after release, want 4", n);
      end
      $display("hold: tail cycles=%0d", n);
   endtask
`endif

   initial begin
      test_reset();
      test_single_call();
      test_intercept();
      test_reversal();
      test_same_floor_door();
      test_async_reset();
`ifdef ELEVATOR_SCHED_HOLD_EN
      test_hold();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, want completion");
      $fatal(1);
   end

endmodule
